// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// mult_share_arb : arbiter + serial shift-add sequencer for the shared signed
//                  multiplier (port A = keypad entry, port B = compute path).
// Optional: define MULT_SAT_EN to saturate the result on overflow.
// Rev 1.0
// ============================================================================
module mult_share_arb #(
  parameter int WIDTH  = 16,
  parameter bit PRIO_B = 1'b1
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] a_op2,
  output logic             done_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b_op1,
  input  logic [WIDTH-1:0] b_op2,
  output logic             done_b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       grant
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] LIM_NEG = PW'(1) << (WIDTH - 1);
  localparam logic [PW-1:0] LIM_POS = LIM_NEG - PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic             r_rearm_a, r_rearm_b;
  logic [1:0]       r_grant;
  logic [PW-1:0]    r_acc, r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_done_a, r_done_b;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;

  logic             w_elig_a, w_elig_b, w_pick_b;
  logic [WIDTH-1:0] w_op1, w_op2, w_mag1, w_mag2;
  logic [WIDTH-1:0] w_prod_lo, w_res;
  logic             w_ovf;

  assign w_elig_a = req_a & r_rearm_a;
  assign w_elig_b = req_b & r_rearm_b;
  assign w_pick_b = w_elig_b & (PRIO_B | ~w_elig_a);

  assign w_op1  = r_grant[1] ? b_op1 : a_op1;
  assign w_op2  = r_grant[1] ? b_op2 : a_op2;
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_mag1 = w_op1[WIDTH-1] ? (~w_op1 + WIDTH'(1)) : w_op1;
  assign w_mag2 = w_op2[WIDTH-1] ? (~w_op2 + WIDTH'(1)) : w_op2;

  // Only the low half of the signed product is ever returned, and negating a
  // zero magnitude yields zero, so a zero product can never come out negative.
  assign w_prod_lo = r_sign ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_ovf     = r_sign ? (r_acc > LIM_NEG) : (r_acc > LIM_POS);

`ifdef MULT_SAT_EN
  assign w_res = w_ovf ? (r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                       : w_prod_lo;
`else
  assign w_res = w_prod_lo;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_elig_a | w_elig_b) w_next = S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_rearm_a <= 1'b1;
      r_rearm_b <= 1'b1;
      r_grant   <= 2'b00;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_done_a  <= 1'b0;
      r_done_b  <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;

      // A low req re-arms the port; a completion disarms it until req drops.
      if (!req_a)                                 r_rearm_a <= 1'b1;
      else if (r_state == S_DONE && r_grant[0])   r_rearm_a <= 1'b0;
      if (!req_b)                                 r_rearm_b <= 1'b1;
      else if (r_state == S_DONE && r_grant[1])   r_rearm_b <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_elig_a | w_elig_b) r_grant <= w_pick_b ? 2'b10 : 2'b01;
        end
        S_LOAD: begin
          r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
          r_mplier <= w_mag2;
          r_sign   <= w_op1[WIDTH-1] ^ w_op2[WIDTH-1];
          r_acc    <= '0;
          r_cnt    <= CW'(WIDTH);
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_done_a <= r_grant[0];
          r_done_b <= r_grant[1];
          r_grant  <= 2'b00;
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

  assign done_a   = r_done_a;
  assign done_b   = r_done_b;
  assign result   = r_result;
  assign overflow = r_ovf;
  assign busy     = (r_state != S_IDLE);
  assign grant    = r_grant;

endmodule
`default_nettype wire

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
Arbiter and sequencer for the calculator's single shared signed 16-bit multiplier.
- Two requesters share it: the keypad entry path (port A, does operand x10 + digit accumulation) and the compute path (port B, does the op1 * op2 result on equal).
- Grants one requester at a time, runs an internal serial shift-add multiply over WIDTH cycles, and returns a signed truncated product plus an overflow flag.
- Sits between the calculator controller FSM and the display/result register.

Parameters:
WIDTH, 16, operand/result width in bits (signed two's complement)
PRIO_B, 1, 1 = port B wins simultaneous requests; 0 = port A wins

Ports:
clk  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
req_a  in  1  port A request, level; hold high with operands stable until done_a
a_op1  in  WIDTH  port A multiplicand, signed
a_op2  in  WIDTH  port A multiplier, signed
done_a  out  1  one-cycle pulse: port A product valid on result
req_b  in  1  port B request, level; same rules as req_a
b_op1  in  WIDTH  port B multiplicand, signed
b_op2  in  WIDTH  port B multiplier, signed
done_b  out  1  one-cycle pulse: port B product valid on result
result  out  WIDTH  signed product, registered, held until next completion
overflow  out  1  registered with result; 1 = true product outside signed WIDTH range
busy  out  1  high in every state except IDLE
grant  out  2  one-hot owner: 01 = A, 10 = B, 00 = none

Behaviour:
- Reset (async, nRST low): state IDLE; done_a = done_b = 0; result = 0; overflow = 0; busy = 0; grant = 00; both rearm flags = 1; internal accumulator and counter cleared.
- Reset mid-operation: aborts immediately, no done pulse is produced, and the requester must re-request.
- FSM states are IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: a requester is eligible when req_x = 1 and its rearm flag = 1.
  - If both are eligible, PRIO_B selects the winner.
  - grant is registered; move to LOAD. If none is eligible, stay in IDLE.
- LOAD (1 cycle):
  - Capture the granted operands.
  - Form unsigned magnitudes, WIDTH bits each; -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1).
  - sign = msb(op1) XOR msb(op2).
  - Clear the 2*WIDTH accumulator and load counter = WIDTH.
- RUN (exactly WIDTH cycles):
  - Each cycle: if the multiplier LSB is 1, add the shifted multiplicand; shift; decrement counter.
  - Exit to DONE when the counter reaches 0.
- DONE (1 cycle):
  - Apply sign by two's-complement negating the 2*WIDTH magnitude when sign = 1 and magnitude != 0. A zero product is never negative.
  - result = low WIDTH bits.
  - overflow = 1 when magnitude > 2^(WIDTH-1)-1 with sign 0, or magnitude > 2^(WIDTH-1) with sign 1.
  - Pulse done_x for the granted port; clear that port's rearm flag; grant = 00; next state IDLE.
- Latency: req sampled high in IDLE at cycle 0 -> done at cycle WIDTH+2 (18 for WIDTH = 16). The first possible new grant is sampled at cycle WIDTH+3.
- Rearm rule: a port's rearm flag sets when its req is sampled low at any clock edge. A req held high through its done does NOT start a second multiply.
- A request arriving while busy waits, with no loss.
- Operand changes after LOAD are ignored.
- Dropping req after grant does not abort; the operation completes and done still pulses.
- done_a and done_b are never high in the same cycle.

Optional Feature:
MULT_SAT_EN
- Defined: on overflow, result saturates to 2^(WIDTH-1)-1 (sign 0) or -2^(WIDTH-1) (sign 1), and overflow is still flagged.
- Undefined: result is the truncated low WIDTH bits of the true product.
- Latency is unchanged in both cases.

Test Plan:
- B: -1 * -1 -> done_b at cycle 18, result = 0x0001, overflow = 0, done_a stays 0.
- B: 128 * 256 -> result = 0x8000, overflow = 1 (MULT_SAT_EN undefined); result = 0x7FFF, overflow = 1 (defined).
- B: -32768 * 1 -> result = 0x8000, overflow = 0; B: -12 * 3000 -> result = 0x7360, overflow = 1 (no sat) / 0x8000 (sat).
- req_a (a: 25 * 10) and req_b (b: -2 * 5) rise on the same edge with PRIO_B = 1 -> done_b at cycle 18, result = 0xFFF6; then done_a at cycle 37, result = 0x00FA.
- req_a held high after done_a for 40 cycles -> no second done_a. Drop req_a 1 cycle, then raise -> new done_a 18 cycles after the re-sample.
- nRST pulsed low at cycle 9 of RUN -> busy = 0, grant = 00, result = 0 immediately, and no done pulse. A subsequent request completes normally.
